uart_rx_fifo_sb_ctrl: RTL
=========================

UART_RX_FIFO_SB_CTRL -- requirements
Module: uart_rx_fifo_sb_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 10_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-003 SHALL have parameter DATA_W, default 8, maximum character width; legal range 5..8.
REQ-004 SHALL have ports:
- clk_i  in  1  system clock; one clock.
- rst_i  in  1  reset, synchronous, active-high.
- addr_i  in  32  byte address of register.
- req_i  in  1  bus request.
- write_enable_i  in  1  1 = write, 0 = read.
- write_data_i  in  32  write data.
- read_data_o  out  32  read data, combinational.
- int_req_o  out  1  level interrupt request.
- rx_i  in  1  asynchronous serial line; idle is high.

Function
REQ-005 SHALL pass rx_i through a 2-FF synchronizer, with both flops reset to 1; all receive logic SHALL use the synchronized value.
REQ-006 SHALL implement receive FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; PARITY is skipped when parity is disabled.
REQ-007 SHALL leave IDLE on a 1->0 transition of the synchronized line and enter START.
REQ-008 SHALL sample each bit at divisor/2 clocks into the bit.
REQ-009 SHALL return to IDLE from START without pushing if the start bit samples high (glitch rejection).
REQ-010 SHALL shift in char_len data bits LSB first; char_len = CHAR_LEN register + 5, clamped to DATA_W.
REQ-011 SHALL set sticky PERR when the sampled parity bit mismatches even parity (ODD=0) or odd parity (ODD=1).
REQ-012 SHALL sample 1 or 2 stop bits per STOPBITS; any stop sample low SHALL set sticky FERR, and the character is still pushed.
REQ-013 SHALL push the character, zero-extended, into the FIFO one clock after the final stop sample.
REQ-014 SHALL assert busy in every state other than IDLE.
REQ-015 SHALL, on push when full without a same-cycle pop, drop the new character, keep FIFO contents, and set sticky OVR.
REQ-016 SHALL, on push and pop in the same cycle while full, perform both with no OVR; same-cycle push and pop at any level SHALL leave level unchanged.
REQ-017 SHALL implement the register map below; reads of unmapped addresses SHALL return 0, and writes to them SHALL be ignored:
- 0x00 DATA, R: head character; a read with req_i=1, write_enable_i=0 pops at the clock edge; reads 0 and no pop when empty.
- 0x04 STATUS, R/W1C: bit0 nonempty, bit1 full, bit2 busy, bit3 OVR, bit4 PERR, bit5 FERR, bit6 TMO; W1C applies to bits 3..6.
- 0x08 LEVEL, R: entry count, 0..FIFO_DEPTH.
- 0x0C DIVISOR, R/W: clocks per bit; 16 bits.
- 0x10 FRAME, R/W: bit0 parity enable, bit1 ODD, bit2 STOPBITS (0 = 1 stop, 1 = 2 stop), bits5:3 CHAR_LEN.
- 0x14 THRESH, R/W: FIFO level for interrupt.
- 0x18 IRQ_EN, R/W: bit0 level IRQ, bit1 error IRQ, bit2 timeout IRQ.
- 0x24 SOFT_RESET, W: any write has the same effect as rst_i.
REQ-018 SHALL ignore writes to 0x0C and 0x10 while busy.
REQ-019 SHALL ignore a write to 0x0C with a value below 4.
REQ-020 SHALL drive int_req_o = (IRQ_EN[0] & level>=THRESH & THRESH!=0) | (IRQ_EN[1] & (OVR|PERR|FERR)) | (IRQ_EN[2] & TMO).
REQ-021 SHALL make a character pushed at edge N readable at 0x00 from cycle N+1.

Reset
REQ-022 SHALL, on rst_i or SOFT_RESET write, set FSM to IDLE and empty the FIFO.
REQ-023 SHALL, on reset, clear all sticky bits, set DIVISOR = CLK_FREQ_HZ/9600, set FRAME = parity off, 1 stop bit, CHAR_LEN = DATA_W-5, set THRESH = 1, and set IRQ_EN = 0.
REQ-024 SHALL, on reset mid-frame, discard the partial character with no push.

Configuration
REQ-025 SHALL, when UART_RX_TIMEOUT_EN is defined, set TMO once the FIFO is nonempty and the line has been idle in IDLE for 32 bit periods.
REQ-026 SHALL restart the idle count of REQ-025 on any push or pop.
REQ-027 SHALL, when UART_RX_TIMEOUT_EN is undefined, tie TMO to 0 and leave no timeout logic in the design.

Structure
REQ-028 SHALL take from shared package uart_rx_pkg the register offset localparams, STATUS bit indices, and rx_state_t enum.
REQ-029 SHALL implement the FIFO as sub-module rx_fifo (parameters DEPTH, WIDTH; push, pop, full, empty, level); FSM and registers stay in the top module.

Verification
REQ-030 SHALL drive 0x55 at DIVISOR=16, 8N1 -> LEVEL=1 and DATA read=0x55, then LEVEL=0, nonempty=0.
REQ-031 SHALL, with FIFO_DEPTH=4, send 5 characters with no reads -> LEVEL=4, OVR=1, and reads return the first 4 characters in order.
REQ-032 SHALL, with odd parity enabled, send 0xA3 with even parity bit -> PERR=1, character pushed; a W1C 0x10 write to 0x04 -> PERR=0.
REQ-033 SHALL apply a 3-clock low glitch on rx_i with DIVISOR=16 -> no push, busy returns to 0.
REQ-034 SHALL set THRESH=3, IRQ_EN=1, send 3 characters -> int_req_o rises after third push and falls after first DATA read.
REQ-035 SHALL write 0x24 mid-frame -> IDLE, LEVEL=0, DIVISOR back to its reset value, no stray push.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: register offsets,
// STATUS/FRAME bit positions, receive FSM states and helpers.
package uart_rx_pkg;

    localparam logic [31:0] REG_DATA       = 32'h00;
    localparam logic [31:0] REG_STATUS     = 32'h04;
    localparam logic [31:0] REG_LEVEL      = 32'h08;
    localparam logic [31:0] REG_DIVISOR    = 32'h0C;
    localparam logic [31:0] REG_FRAME      = 32'h10;
    localparam logic [31:0] REG_THRESH     = 32'h14;
    localparam logic [31:0] REG_IRQ_EN     = 32'h18;
    localparam logic [31:0] REG_SOFT_RESET = 32'h24;

    localparam int ST_NONEMPTY = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_BUSY     = 2;
    localparam int ST_OVR      = 3;
    localparam int ST_PERR     = 4;
    localparam int ST_FERR     = 5;
    localparam int ST_TMO      = 6;

    localparam int FR_PAR_EN = 0;
    localparam int FR_ODD    = 1;
    localparam int FR_STOP2  = 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // CHAR_LEN field + 5, never wider than the data path
    function automatic logic [3:0] char_len(input logic [2:0] len_field,
                                            input int         data_w);
        logic [3:0] n;
        n = {1'b0, len_field} + 4'd5;
        if (n > 4'(data_w)) n = 4'(data_w);
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sb_ctrl_fifo.sv
// Receive FIFO: power-of-two ring buffer with occupancy count.
// A push while full only lands when a pop frees a slot in the same cycle.
import uart_rx_pkg::*;

module rx_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push & ~do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop & ~do_push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo_sb_ctrl.sv
// UART receiver with FIFO and register interface.
// Optional receive timeout: define UART_RX_TIMEOUT_EN.
import uart_rx_pkg::*;

module uart_rx_fifo_sb_ctrl #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int FIFO_DEPTH  = 16,
    parameter int DATA_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        int_req_o,
    input  logic        rx_i
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [15:0] DIV_RST   = 16'(CLK_FREQ_HZ / 9600);
    localparam logic [5:0]  FRAME_RST = {3'(DATA_W - 5), 3'b000};

    logic rx_s1, rx_s2, rx_prev;

    rx_state_t         state;
    logic [15:0]       cnt_q;
    logic [3:0]        bit_q;
    logic              stop_q;
    logic              par_q;
    logic [DATA_W-1:0] shreg_q;
    logic              push_q;

    logic [15:0]   div_q;
    logic [5:0]    frame_q;
    logic [LW-1:0] thresh_q;
    logic [2:0]    irq_en_q;
    logic          ovr_q, perr_q, ferr_q, tmo_q;

    logic              fifo_full, fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic [DATA_W-1:0] fifo_head;

    logic wr, rd, srst, busy, pop;
    logic sel_data, sel_status, sel_level, sel_div;
    logic sel_frame, sel_thresh, sel_irq_en, sel_srst;
    logic [3:0]  clen;
    logic [15:0] half;
    logic        bit_done;
    logic        perr_set, ferr_set, ovr_set;

    assign sel_data   = (addr_i == REG_DATA);
    assign sel_status = (addr_i == REG_STATUS);
    assign sel_level  = (addr_i == REG_LEVEL);
    assign sel_div    = (addr_i == REG_DIVISOR);
    assign sel_frame  = (addr_i == REG_FRAME);
    assign sel_thresh = (addr_i == REG_THRESH);
    assign sel_irq_en = (addr_i == REG_IRQ_EN);
    assign sel_srst   = (addr_i == REG_SOFT_RESET);

    assign wr   = req_i & write_enable_i;
    assign rd   = req_i & ~write_enable_i;
    assign srst = rst_i | (wr & sel_srst);
    assign busy = (state != RX_IDLE);
    assign pop  = rd & sel_data & ~fifo_empty;

    assign clen     = char_len(frame_q[5:3], DATA_W);
    assign half     = {1'b0, div_q[15:1]};
    assign bit_done = (cnt_q == div_q - 16'd1);

    assign perr_set = (state == RX_PARITY) & bit_done &
                      (rx_s2 != (par_q ^ frame_q[FR_ODD]));
    assign ferr_set = (state == RX_STOP) & bit_done & ~rx_s2;
    assign ovr_set  = push_q & fifo_full & ~pop;

    always_ff @(posedge clk_i) begin
        if (srst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Start sample at half a bit, then one sample per full bit period
    always_ff @(posedge clk_i) begin
        if (srst) begin
            state   <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            shreg_q <= '0;
            push_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (rx_prev & ~rx_s2) begin
                        state <= RX_START;
                        cnt_q <= 16'd1;
                    end
                end
                RX_START: begin
                    if (cnt_q == half) begin
                        cnt_q <= '0;
                        if (rx_s2) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            bit_q   <= '0;
                            par_q   <= 1'b0;
                            shreg_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        shreg_q[bit_q[BW-1:0]] <= rx_s2;
                        par_q <= par_q ^ rx_s2;
                        if (bit_q == clen - 4'd1) begin
                            bit_q  <= '0;
                            stop_q <= 1'b0;
                            state  <= frame_q[FR_PAR_EN] ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_PARITY: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        state <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (stop_q == frame_q[FR_STOP2]) begin
                            state  <= RX_IDLE;
                            push_q <= 1'b1;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst) begin
            div_q    <= DIV_RST;
            frame_q  <= FRAME_RST;
            thresh_q <= LW'(1);
            irq_en_q <= '0;
        end else if (wr) begin
            unique case (1'b1)
                sel_div: begin
                    if (~busy && write_data_i >= 32'd4)
                        div_q <= write_data_i[15:0];
                end
                sel_frame: begin
                    if (~busy) frame_q <= write_data_i[5:0];
                end
                sel_thresh: thresh_q <= write_data_i[LW-1:0];
                sel_irq_en: irq_en_q <= write_data_i[2:0];
                default: ;
            endcase
        end
    end

    // A new event in the same cycle as its W1C keeps the flag set
    always_ff @(posedge clk_i) begin
        if (srst) begin
            ovr_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_set  | (ovr_q  & ~(wr & sel_status & write_data_i[ST_OVR]));
            perr_q <= perr_set | (perr_q & ~(wr & sel_status & write_data_i[ST_PERR]));
            ferr_q <= ferr_set | (ferr_q & ~(wr & sel_status & write_data_i[ST_FERR]));
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [20:0] idle_cnt_q;
    logic [20:0] idle_lim;
    logic        idle_run;
    logic        tmo_set;

    assign idle_lim = {div_q, 5'b0};
    assign idle_run = (state == RX_IDLE) & ~fifo_empty & rx_s2 & ~push_q & ~pop;
    assign tmo_set  = idle_run & (idle_cnt_q == idle_lim - 21'd1);

    always_ff @(posedge clk_i) begin
        if (srst) begin
            idle_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            if (~idle_run)
                idle_cnt_q <= '0;
            else if (idle_cnt_q != idle_lim)
                idle_cnt_q <= idle_cnt_q + 21'd1;
            tmo_q <= tmo_set | (tmo_q & ~(wr & sel_status & write_data_i[ST_TMO]));
        end
    end
`else
    assign tmo_q = 1'b0;
`endif

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (srst),
        .push  (push_q),
        .pop   (pop),
        .wdata (shreg_q),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        read_data_o = '0;
        unique case (1'b1)
            sel_data:   read_data_o = fifo_empty ? 32'd0 : 32'(fifo_head);
            sel_status: read_data_o = {25'd0, tmo_q, ferr_q, perr_q, ovr_q,
                                       busy, fifo_full, ~fifo_empty};
            sel_level:  read_data_o = 32'(fifo_level);
            sel_div:    read_data_o = 32'(div_q);
            sel_frame:  read_data_o = 32'(frame_q);
            sel_thresh: read_data_o = 32'(thresh_q);
            sel_irq_en: read_data_o = 32'(irq_en_q);
            default:    read_data_o = '0;
        endcase
    end

    assign int_req_o = (irq_en_q[0] & (fifo_level >= thresh_q) & (thresh_q != '0)) |
                       (irq_en_q[1] & (ovr_q | perr_q | ferr_q)) |
                       (irq_en_q[2] & tmo_q);

endmodule
